gol_sequencer: RTL and testbench

Phase scheduler for the Game-of-Life core: decides when the board is randomized, when a new generation is computed, and when the computed generation is committed to the displayed board. It sits between the user controls / `hvsync_generator` and the three board engines (init, update, copy), driving each with a one-cycle start pulse and waiting for its one-cycle done pulse. Commits are aligned to a vsync rising edge so the visible board never tears mid-frame.

---
 rtl/gol_sequencer.sv | 107 ++++++++++
 tb/tb_gol_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gol_sequencer.sv
// Game-of-Life phase scheduler: sequences randomize/update/commit engines and
// aligns each board commit to a vsync rising edge so the display never tears.
module gol_sequencer #(
  parameter int CLOCK_FREQ = 24000000,
  parameter int UPDATE_HZ  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        step_req,
  input  logic        rand_req,
  input  logic        vsync_in,
  output logic        init_start,
  output logic        upd_start,
  output logic        copy_start,
  input  logic        init_done,
  input  logic        upd_done,
  input  logic        copy_done,
  output logic [2:0]  phase,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam logic [31:0] INTERVAL = 32'(CLOCK_FREQ / UPDATE_HZ);

  typedef enum logic [2:0] {
    S_INIT, W_INIT, IDLE, S_UPD, W_UPD, WAIT_VS, S_COPY, W_COPY
  } state_t;

  state_t      state, next_state;
  logic [31:0] timer;
  logic        step_pend;
  logic        vs_q;
  logic        vs_edge;
  logic        trigger;

  assign vs_edge = vsync_in & ~vs_q;
  assign trigger = (state == IDLE) & vs_edge & ((run_en & (timer >= INTERVAL)) | step_pend);

  // An S_x state holds until its registered start pulse has been issued; this
  // gives the boot pulse one cycle after reset release and a single-cycle S_x
  // when entered from IDLE, where the pulse rises together with the state.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (init_start) next_state = W_INIT;
      W_INIT:  if (init_done) next_state = IDLE;
      IDLE:    if (trigger) next_state = rand_req ? S_INIT : S_UPD;
      S_UPD:   if (upd_start) next_state = W_UPD;
      W_UPD:   if (upd_done) next_state = WAIT_VS;
      WAIT_VS: if (vs_edge) next_state = S_COPY;
      S_COPY:  if (copy_start) next_state = W_COPY;
      W_COPY:  if (copy_done) next_state = IDLE;
      default: next_state = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_start <= 1'b0;
      upd_start  <= 1'b0;
      copy_start <= 1'b0;
      vs_q       <= 1'b1;
      timer      <= '0;
      step_pend  <= 1'b0;
      gen_count  <= '0;
    end else begin
      state      <= next_state;
      init_start <= (next_state == S_INIT);
      upd_start  <= (next_state == S_UPD);
      copy_start <= (next_state == S_COPY);
      vs_q       <= vsync_in;

      if (state == IDLE) begin
        if (trigger)
          timer <= '0;
        else if (run_en && (timer < INTERVAL))
          timer <= timer + 32'd1;
      end

      if (trigger)
        step_pend <= 1'b0;
      else if (step_req && !run_en)
        step_pend <= 1'b1;

      if ((state == W_INIT) && init_done)
        gen_count <= '0;
      else if ((state == W_COPY) && copy_done)
        gen_count <= gen_count + 16'd1;
    end
  end

  always_comb begin
    phase = 3'd0;
    case (state)
      S_INIT, W_INIT: phase = 3'd1;
      S_UPD, W_UPD:   phase = 3'd2;
      WAIT_VS:        phase = 3'd3;
      S_COPY, W_COPY: phase = 3'd4;
      default:        phase = 3'd0;
    endcase
  end

  assign busy = (phase != 3'd0);

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed bench for gol_sequencer: boot, free run, pause/step, randomize,
// spurious done pulses and asynchronous reset in the middle of a commit.
module tb_gol_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en, step_req, rand_req, vsync_in;
  logic        init_start, upd_start, copy_start;
  logic        init_done, upd_done, copy_done;
  logic [2:0]  phase;
  logic        busy;
  logic [15:0] gen_count;

  int n_checks = 0;
  int n_err    = 0;

  gol_sequencer #(.CLOCK_FREQ(100), .UPDATE_HZ(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step_req   (step_req),
    .rand_req   (rand_req),
    .vsync_in   (vsync_in),
    .init_start (init_start),
    .upd_start  (upd_start),
    .copy_start (copy_start),
    .init_done  (init_done),
    .upd_done   (upd_done),
    .copy_done  (copy_done),
    .phase      (phase),
    .busy       (busy),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
  endtask

  // Trigger conditions must already hold; runs one update and commit.
  // With abort set, returns while the sequencer sits in W_COPY.
  task automatic do_update(input int exp_gen, input bit abort);
    vs_pulse();
    chk("upd_start_rise", upd_start, 1);
    chk("no_init_on_upd", init_start, 0);
    chk("phase_s_upd", phase, 2);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("upd_done_same_cycle_ignored", phase, 2);
    chk("upd_start_one_cycle", upd_start, 0);
    tick();
    tick();
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("phase_wait_vs", phase, 3);
    repeat (5) tick();
    chk("hold_wait_vs", phase, 3);
    chk("no_copy_before_vs", copy_start, 0);
    vs_pulse();
    chk("copy_start_rise", copy_start, 1);
    chk("phase_s_copy", phase, 4);
    tick();
    chk("copy_start_one_cycle", copy_start, 0);
    chk("phase_w_copy", phase, 4);
    if (abort) return;
    tick();
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("phase_idle_after_copy", phase, 0);
    chk("gen_count_commit", gen_count, exp_gen);
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; step_req = 1'b0; rand_req = 1'b0; vsync_in = 1'b0;
    init_done = 1'b0; upd_done = 1'b0; copy_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", phase, 1);
    chk("rst_busy", busy, 1);
    chk("rst_init_start", init_start, 0);
    chk("rst_upd_start", upd_start, 0);
    chk("rst_copy_start", copy_start, 0);
    chk("rst_gen", gen_count, 0);

    // Boot
    rst_n = 1'b1;
    tick();
    chk("boot_init_start", init_start, 1);
    chk("boot_phase", phase, 1);
    tick();
    chk("boot_init_start_low", init_start, 0);
    repeat (3) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("boot_idle_phase", phase, 0);
    chk("boot_idle_busy", busy, 0);
    chk("boot_gen", gen_count, 0);

    // Free running: three generations, spurious copy_done while idle
    run_en = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      repeat (12) tick();
      chk("no_trigger_without_vs", phase, 0);
      copy_done = 1'b1;
      tick();
      copy_done = 1'b0;
      chk("copy_done_idle_ignored_phase", phase, 0);
      chk("copy_done_idle_ignored_gen", gen_count, g - 1);
      do_update(g, 1'b0);
    end

    // Pause with saturated timer, then a single step
    repeat (12) tick();
    run_en = 1'b0;
    vs_pulse();
    chk("paused_no_trigger", phase, 0);
    repeat (3) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (3) tick();
    chk("step_waits_for_vs", phase, 0);
    do_update(4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      repeat (10) tick();
      vs_pulse();
      chk("after_step_idle", phase, 0);
      chk("after_step_gen", gen_count, 4);
    end

    // Pending step plus timer expiry on the same edge: one generation only
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    run_en = 1'b1;
    repeat (12) tick();
    do_update(5, 1'b0);
    run_en = 1'b0;
    repeat (5) tick();
    vs_pulse();
    chk("step_cleared_by_timer_trigger", phase, 0);
    chk("single_gen_gen", gen_count, 5);

    run_en = 1'b1;
    for (int g = 6; g <= 7; g++) begin
      repeat (12) tick();
      do_update(g, 1'b0);
    end

    // Randomize
    repeat (12) tick();
    rand_req = 1'b1;
    vs_pulse();
    chk("rand_init_start", init_start, 1);
    chk("rand_no_upd_start", upd_start, 0);
    chk("rand_phase", phase, 1);
    chk("rand_gen_before_done", gen_count, 7);
    rand_req = 1'b0;
    tick();
    chk("rand_init_start_low", init_start, 0);
    tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("rand_idle", phase, 0);
    chk("rand_gen_cleared", gen_count, 0);

    // Asynchronous reset while in W_COPY
    repeat (12) tick();
    do_update(1, 1'b0);
    repeat (12) tick();
    do_update(2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_phase", phase, 1);
    chk("midrst_busy", busy, 1);
    chk("midrst_gen", gen_count, 0);
    chk("midrst_copy_start", copy_start, 0);
    chk("midrst_init_start", init_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midrst_reinit_start", init_start, 1);
    chk("midrst_reinit_phase", phase, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
